// File: rtl/fifo_reader.sv
// Drains a show-ahead 1-bit FIFO and assembles WIDTH consecutive entries into one word,
// then holds that word until the downstream side accepts it.
module fifo_reader #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         fifo_empty,
  input  logic                         fifo_dout,
  output logic                         fifo_deq,
  output logic                         word_valid,
  output logic [WIDTH-1:0]             word_data,
  input  logic                         word_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] data_d;
  logic             last_bit;

  // Reset gating keeps the strobe quiet while the block is held in reset.
  assign fifo_deq = RST_N && (state_q == COLLECT) && en && !fifo_empty && !flush;

  // Unwritten bits are zero, so inserting the new bit is a simple OR.
  assign pos      = LSB_FIRST ? cnt_q : (CW'(WIDTH - 1) - cnt_q);
  assign data_d   = data_q | (WIDTH'(fifo_dout) << pos);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (flush) begin
            cnt_q  <= '0;
            data_q <= '0;
          end else if (fifo_deq) begin
            data_q <= data_d;
            cnt_q  <= cnt_q + CW'(1);
            if (last_bit) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Flush and en are deliberately ignored so a finished word is never lost.
          if (word_ready) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign word_valid = valid_q;
  assign word_data  = data_q;
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: LSB-first and MSB-first instances share one
// modelled upstream FIFO and are checked against a cycle-level reference model.
module tb_fifo_reader;

  localparam int unsigned W = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_dout = 1'b0;
  logic       word_ready = 1'b0;

  logic       deq_l, deq_m;
  logic       valid_l, valid_m;
  logic [7:0] data_l, data_m;
  logic [3:0] cnt_l, cnt_m;

  always #5 CLK = ~CLK;

  fifo_reader #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_deq(deq_l),
    .word_valid(valid_l), .word_data(data_l), .word_ready(word_ready),
    .bit_count(cnt_l)
  );

  fifo_reader #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .CLK(CLK), .RST_N(RST_N), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_deq(deq_m),
    .word_valid(valid_m), .word_data(data_m), .word_ready(word_ready),
    .bit_count(cnt_m)
  );

  bit         fq[$];
  logic [7:0] exp_l[$];
  logic [7:0] exp_m[$];
  int         checks = 0;
  int         failures = 0;
  int         mcnt = 0;
  bit         mhold = 1'b0;
  bit         gap = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // bits[i] is the i-th entry dequeued.
  task automatic push_bits(input logic [7:0] bits, input int n, input bit expect_word);
    logic [7:0] rev;
    for (int i = 0; i < n; i++) fq.push_back(bits[i]);
    if (expect_word) begin
      for (int i = 0; i < 8; i++) rev[7-i] = bits[i];
      exp_l.push_back(bits);
      exp_m.push_back(rev);
    end
  endtask

  // One clock: drive at negedge, check strobe/held word before the edge, state after it.
  task automatic cycle();
    bit exp_deq;
    bit dq;
    fifo_empty = (fq.size() == 0) || gap;
    fifo_dout  = fifo_empty ? 1'b0 : fq[0];
    #1;
    exp_deq = !mhold && en && !fifo_empty && !flush;
    check("deq_l", 32'(deq_l), 32'(exp_deq));
    check("deq_m", 32'(deq_m), 32'(exp_deq));
    dq = deq_l;
    if (mhold) begin
      check("sb_has_word", 32'(exp_l.size() > 0), 32'd1);
      if (exp_l.size() > 0) begin
        check("data_l", 32'(data_l), 32'(exp_l[0]));
        check("data_m", 32'(data_m), 32'(exp_m[0]));
        if (word_ready) begin
          void'(exp_l.pop_front());
          void'(exp_m.pop_front());
        end
      end
    end
    if (!mhold) begin
      if (flush) mcnt = 0;
      else if (exp_deq) begin
        mcnt++;
        if (mcnt == W) mhold = 1'b1;
      end
    end else if (word_ready) begin
      mhold = 1'b0;
      mcnt  = 0;
    end
    @(posedge CLK);
    if (dq && fq.size() > 0) void'(fq.pop_front());
    @(negedge CLK);
    check("cnt_l", 32'(cnt_l), 32'(mcnt));
    check("cnt_m", 32'(cnt_m), 32'(mcnt));
    check("valid_l", 32'(valid_l), 32'(mhold));
    check("valid_m", 32'(valid_m), 32'(mhold));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_idle(input bit rnd_en);
    int k = 0;
    while ((fq.size() > 0 || mhold) && k < 400) begin
      en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      k++;
    end
    en = 1'b1;
    check("idle_timeout", 32'(k < 400), 32'd1);
  endtask

  task automatic run_until_hold();
    int k = 0;
    while (!mhold && k < 100) begin
      cycle();
      k++;
    end
    check("hold_timeout", 32'(mhold), 32'd1);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse(input string tag);
    #2 RST_N = 1'b0;
    #1;
    check({tag, "_cnt"}, 32'(cnt_l), 32'd0);
    check({tag, "_valid"}, 32'(valid_l), 32'd0);
    check({tag, "_data_l"}, 32'(data_l), 32'd0);
    check({tag, "_data_m"}, 32'(data_m), 32'd0);
    check({tag, "_deq"}, 32'(deq_l), 32'd0);
    #1;
    RST_N = 1'b1;
    en    = 1'b0;
    mcnt  = 0;
    mhold = 1'b0;
    fq.delete();
    @(negedge CLK);
    check({tag, "_post_cnt"}, 32'(cnt_m), 32'd0);
    check({tag, "_post_valid"}, 32'(valid_m), 32'd0);
    en = 1'b1;
  endtask

  initial begin
    #1 RST_N = 1'b0;
    #1;
    check("rst_cnt", 32'(cnt_l), 32'd0);
    check("rst_valid", 32'(valid_l), 32'd0);
    check("rst_data", 32'(data_l), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N      = 1'b1;
    en         = 1'b1;
    word_ready = 1'b1;
    cycle();

    // Reference words back to back: 0x4D / 0xB2, then a second word.
    push_bits(8'h4D, 8, 1'b1);
    push_bits(8'hA7, 8, 1'b1);
    run_idle(1'b0);

    // Empty gap after three bits.
    push_bits(8'h4D, 8, 1'b1);
    run(3);
    gap = 1'b1;
    run(5);
    check("gap_cnt", 32'(cnt_l), 32'd3);
    gap = 1'b0;
    run_idle(1'b0);

    // Completed word held with ready low while flush and data are present.
    word_ready = 1'b0;
    push_bits(8'h3C, 8, 1'b1);
    run_until_hold();
    flush = 1'b1;
    push_bits(8'h81, 8, 1'b1);
    run(4);
    check("hold_cnt", 32'(cnt_l), 32'd8);
    flush      = 1'b0;
    word_ready = 1'b1;
    run_idle(1'b0);

    // Flush after five ones, then a fresh word.
    push_bits(8'hFF, 5, 1'b0);
    run(5);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push_bits(8'h12, 8, 1'b1);
    run_idle(1'b0);

    // Reset mid-word at bit 6, then reset while holding.
    push_bits(8'h5A, 8, 1'b0);
    run(6);
    check("pre_rst_cnt", 32'(cnt_l), 32'd6);
    rst_pulse("rst_mid");
    run(3);
    word_ready = 1'b0;
    push_bits(8'hC3, 8, 1'b1);
    run_until_hold();
    rst_pulse("rst_hold");
    void'(exp_l.pop_front());
    void'(exp_m.pop_front());
    word_ready = 1'b1;
    run(3);
    push_bits(8'h96, 8, 1'b1);
    run_idle(1'b0);

    // Random words under random en.
    for (int i = 0; i < 4; i++) push_bits(8'($urandom), 8, 1'b1);
    run_idle(1'b1);
    check("sb_drained", 32'(exp_l.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
